weight_mem_ctrl: RTL and testbench
==================================

// Module: weight_mem_ctrl
// PURPOSE
//  Per-layer controller for the bank of per-neuron weights_memory instances.
//  Write side: takes a valid/ready stream of {layer, neuron, weight, last} beats.
//    It decodes these into a one-hot write enable plus an auto-incrementing write address.
//  Read side: sequences inference reads over addresses 0..num_weights-1, broadcast to all neurons.
//  Blocks weight loading while an inference is in progress.
// PARAMETERS
//  data_width    16   weight bit-width
//  address_width 10   memory address width; must satisfy 2**address_width >= num_weights
//  num_weights   784  weights per neuron
//  num_neurons   30   neuron memories in this layer
//  layer_no      1    layer ID this controller answers to
// PORTS
//  clk            in   1              system clock; all logic on rising edge
//  rst_n          in   1              synchronous, active-low reset
//  cfg_valid      in   1              weight beat valid
//  cfg_ready      out  1              beat accepted when cfg_valid & cfg_ready
//  cfg_layer      in   8              target layer ID
//  cfg_neuron     in   8              target neuron index
//  cfg_data       in   data_width     weight value
//  cfg_last       in   1              final weight of this neuron
//  wr_en          out  num_neurons    one-hot write enable to the neuron memories
//  wr_addr        out  address_width  write address
//  wr_data        out  data_width     write data
//  start          in   1              inference start pulse
//  in_valid       in   1              input feature available; read advances only while high
//  rd_en          out  1              read enable, broadcast to all memories
//  rd_addr        out  address_width  read address
//  rd_valid       out  1              weight_out valid this cycle (rd_en delayed 1 cycle)
//  busy           out  1              inference sequence active
//  done           out  1              1-cycle pulse after the last valid read
//  err            out  1              sticky load-protocol error (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): every output and register goes to 0.
//    This covers state=IDLE, wr_addr, rd_addr, err, all enables and pulses.
//    Reset mid-operation aborts the operation; no done pulse is produced.
//  FSM states: IDLE, READ, DRAIN, DONE.
//    IDLE -> READ on start.
//    READ -> DRAIN once the rd_en cycle with rd_addr=num_weights-1 has issued.
//    DRAIN -> DONE after 1 cycle.
//    DONE -> IDLE after 1 cycle.
//  cfg_ready = (state==IDLE) & ~start (combinational).
//    If start and cfg_valid are both high in IDLE, start wins and the beat waits.
//  Accepted beat, registered for 1 cycle of latency:
//    If cfg_layer==layer_no and cfg_neuron<num_neurons:
//      wr_en[cfg_neuron]=1, wr_data=cfg_data, wr_addr=the current write counter.
//    Otherwise the beat is consumed and dropped: wr_en=0, counter unchanged.
//  Write counter: advances by 1 on each written beat.
//    Returns to 0 after a beat with cfg_last=1, or after the beat written at num_weights-1.
//    It never exceeds num_weights-1.
//  READ: rd_en = in_valid; rd_addr increments after each rd_en cycle.
//    rd_addr holds its value while in_valid=0.
//    rd_addr returns to 0 on leaving READ.
//  rd_valid = rd_en registered, which matches the 1-cycle memory read latency.
//  done pulses in DONE, the cycle after the final rd_valid.
//  busy = (state != IDLE).
//  start while busy is ignored.
// CONFIGURATION
//  WEIGHT_LOAD_CHECK_EN defined: err is set and held until reset in two cases:
//    - a written beat with cfg_last=1 arrives at write address != num_weights-1;
//    - a written beat arrives at num_weights-1 with cfg_last=0.
//  Write behaviour is unchanged either way.
//  WEIGHT_LOAD_CHECK_EN undefined: err is tied to 0; no checker logic is built.
// TESTING
//  Load neuron 3 with 784 beats, last on beat 784 ->
//    wr_en=1<<3 for addresses 0..783, wr_addr back to 0, err=0.
//  Beat with cfg_layer=2 (layer_no=1), or with cfg_neuron=30 ->
//    cfg_ready=1, wr_en=0, write counter unchanged.
//  start with in_valid tied high ->
//    rd_addr 0..783 on consecutive cycles, rd_valid lags by 1, done 2 cycles after the last rd_en.
//  in_valid low for 5 cycles at rd_addr=100 ->
//    rd_en=0 and rd_addr=100 are held; total read cycles still 784.
//  start and cfg_valid high in IDLE ->
//    cfg_ready=0 and busy=1 next cycle; the beat is accepted only after done.
//  With WEIGHT_LOAD_CHECK_EN: cfg_last on beat 10 -> err=1 and sticky until rst_n=0.
//    rst_n=0 mid-READ -> busy=0 next cycle, no done pulse.

Source files
------------

// File: rtl/weight_mem_ctrl.sv
// Per-layer weight memory controller: stream-fed weight loader plus inference read sequencer.
// Optional WEIGHT_LOAD_CHECK_EN builds a sticky load-protocol checker driving err.
//
// state | meaning
// IDLE  | waiting for start; weight beats accepted
// READ  | issuing rd_en over addresses 0..num_weights-1 as in_valid allows
// DRAIN | final read data returning from memory
// DONE  | done pulse, then back to IDLE
module weight_mem_ctrl #(
  parameter int data_width    = 16,
  parameter int address_width = 10,
  parameter int num_weights   = 784,
  parameter int num_neurons   = 30,
  parameter int layer_no      = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [7:0]               cfg_layer,
  input  logic [7:0]               cfg_neuron,
  input  logic [data_width-1:0]    cfg_data,
  input  logic                     cfg_last,
  output logic [num_neurons-1:0]   wr_en,
  output logic [address_width-1:0] wr_addr,
  output logic [data_width-1:0]    wr_data,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     rd_en,
  output logic [address_width-1:0] rd_addr,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [address_width-1:0] last_addr  = address_width'(num_weights - 1);
  localparam logic [7:0]               layer_id   = 8'(layer_no);
  localparam logic [8:0]               neuron_cnt = 9'(num_neurons);
  localparam logic [num_neurons-1:0]   one_lsb    = num_neurons'(1);

  state_t                   state;
  logic [address_width-1:0] wr_cnt;
  logic                     beat_acc;
  logic                     beat_hit;
  logic                     cnt_at_last;

  // start outranks a pending beat so a load can never begin under a read
  assign cfg_ready   = (state == IDLE) & ~start;
  assign beat_acc    = cfg_valid & cfg_ready;
  assign beat_hit    = beat_acc & (cfg_layer == layer_id) & ({1'b0, cfg_neuron} < neuron_cnt);
  assign cnt_at_last = (wr_cnt == last_addr);
  assign rd_en       = (state == READ) & in_valid;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_addr  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      done     <= 1'b0;
      case (state)
        IDLE: if (start) state <= READ;
        READ: begin
          if (in_valid) begin
            if (rd_addr == last_addr) begin
              state   <= DRAIN;
              rd_addr <= '0;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_cnt  <= '0;
    end else begin
      wr_en <= '0;
      if (beat_hit) begin
        wr_en   <= one_lsb << cfg_neuron;
        wr_addr <= wr_cnt;
        wr_data <= cfg_data;
        wr_cnt  <= (cfg_last || cnt_at_last) ? '0 : wr_cnt + 1'b1;
      end
    end
  end

`ifdef WEIGHT_LOAD_CHECK_EN
  // last must coincide exactly with the final address of a neuron
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (beat_hit && (cfg_last != cnt_at_last)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Randomized self-checking bench for weight_mem_ctrl against a behavioural model.
// Expected err follows the model only when WEIGHT_LOAD_CHECK_EN is defined.
module tb_weight_mem_ctrl;

  localparam int NW    = 784;
  localparam int NN    = 30;
  localparam int LAYER = 1;
`ifdef WEIGHT_LOAD_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready, cfg_last;
  logic [7:0]  cfg_layer, cfg_neuron;
  logic [15:0] cfg_data;
  logic [29:0] wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start, in_valid, rd_en, rd_valid, busy, done, err;
  logic [9:0]  rd_addr;

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;   // model write counter
  bit m_err  = 0;   // model protocol error

  weight_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_layer(cfg_layer),
    .cfg_neuron(cfg_neuron), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .in_valid(in_valid), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0;
    m_err = 0;
  endtask

  task automatic send_beat(input logic [7:0] layer, input logic [7:0] neuron,
                           input logic [15:0] data, input logic last);
    bit          acc = 0;
    bit          hit;
    logic [29:0] exp_en;
    cfg_valid = 1'b1; cfg_layer = layer; cfg_neuron = neuron; cfg_data = data; cfg_last = last;
    for (int c = 0; c < 2000 && !acc; c++) begin
      #1 acc = cfg_ready;
      @(posedge clk);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL beat_accept timeout: cfg_ready never high");
      return;
    end
    hit = (layer == 8'(LAYER)) && (int'(neuron) < NN);
    if (hit) begin
      exp_en = 30'(1) << neuron;
      checks++;
      if (wr_en !== exp_en || wr_addr !== 10'(m_cnt) || wr_data !== data) begin
        errors++;
        $display("FAIL beat_write: wr_en=%h wr_addr=%0d wr_data=%h expected wr_en=%h wr_addr=%0d wr_data=%h",
                 wr_en, wr_addr, wr_data, exp_en, m_cnt, data);
      end
      if ((last && m_cnt != NW-1) || (!last && m_cnt == NW-1)) m_err = 1;
      m_cnt = (last || m_cnt == NW-1) ? 0 : m_cnt + 1;
    end else begin
      checks++;
      if (wr_en !== '0) begin
        errors++;
        $display("FAIL beat_drop: wr_en=%h expected 0", wr_en);
      end
    end
    checks++;
    if (err !== (m_err & CHK_EN)) begin
      errors++;
      $display("FAIL beat_err: err=%b expected %b", err, m_err & CHK_EN);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_valid = 0; cfg_layer = 0; cfg_neuron = 0; cfg_data = 0; cfg_last = 0;
    start = 0; in_valid = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0; m_err = 0;
    #1;
    checks++;
    if (busy !== 0 || done !== 0 || rd_en !== 0 || rd_valid !== 0 || rd_addr !== 0 ||
        wr_en !== 0 || wr_addr !== 0 || wr_data !== 0 || err !== 0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b rd_valid=%b rd_addr=%0d wr_en=%h wr_addr=%0d wr_data=%h err=%b expected all 0",
               busy, done, rd_en, rd_valid, rd_addr, wr_en, wr_addr, wr_data, err);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cfg_ready: cfg_ready=%b expected 1", cfg_ready);
    end
  endtask

  task automatic test_load_neuron3();
    for (int i = 0; i < NW; i++) send_beat(8'd1, 8'd3, 16'($urandom), i == NW-1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL load3_err: err=%b expected 0", err);
    end
    send_beat(8'd1, 8'd5, 16'($urandom), 1'b0);   // must land at address 0
  endtask

  task automatic test_drop();
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_ready: cfg_ready=%b expected 1", cfg_ready);
    end
    send_beat(8'd2, 8'd3, 16'($urandom), 1'b0);
    send_beat(8'd1, 8'd30, 16'($urandom), 1'b1);
    for (int i = 0; i < 8; i++)
      send_beat(8'($urandom_range(2, 255)), 8'($urandom_range(30, 255)), 16'($urandom), 1'($urandom));
    send_beat(8'd1, 8'd5, 16'($urandom), 1'b0);   // counter must have stayed put
  endtask

  task automatic test_err();
    do_reset();
    for (int i = 1; i <= 10; i++) send_beat(8'd1, 8'd0, 16'($urandom), i == 10);
    for (int i = 0; i < 5; i++)   send_beat(8'd1, 8'd1, 16'($urandom), 1'b0);
    do_reset();
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: err=%b expected 0", err);
    end
  endtask

  task automatic test_random_load();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) begin
        @(posedge clk); @(negedge clk);
        checks++;
        if (wr_en !== '0) begin
          errors++;
          $display("FAIL idle_gap: wr_en=%h expected 0", wr_en);
        end
      end
      send_beat(($urandom_range(3) == 0) ? 8'd2 : 8'd1, 8'($urandom_range(35)),
                16'($urandom), $urandom_range(7) == 0);
    end
  endtask

  task automatic run_read(input int stall_at, input int stall_len, input int iv_pct, input bit poke);
    int   reads = 0, since = 0, obs = 0, stall_left = stall_len;
    bit   prev_en = 0, iv, e_en;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 5000 && since < 3; c++) begin
      if (reads == stall_at && stall_left > 0) begin
        iv = 0; stall_left--;
      end else begin
        iv = ($urandom_range(99) < iv_pct);
      end
      in_valid = iv;
      start = poke && reads < NW && $urandom_range(15) == 0;
      #1;
      e_en = (reads < NW) && iv;
      checks++;
      if (rd_en !== e_en || rd_addr !== ((reads < NW) ? 10'(reads) : 10'd0) || rd_valid !== prev_en ||
          done !== (since == 2) || busy !== (reads < NW || since <= 2)) begin
        errors++;
        $display("FAIL read_seq: read=%0d rd_en=%b rd_addr=%0d rd_valid=%b done=%b busy=%b expected %b %0d %b %b %b",
                 reads, rd_en, rd_addr, rd_valid, done, busy, e_en, (reads < NW) ? reads : 0, prev_en,
                 since == 2, reads < NW || since <= 2);
      end
      obs += int'(rd_en);
      prev_en = e_en;
      @(posedge clk); @(negedge clk);
      if (e_en) reads++;
      if (reads == NW) since++;
    end
    start = 1'b0; in_valid = 1'b0;
    checks++;
    if (since < 3 || obs != NW) begin
      errors++;
      $display("FAIL read_total: rd_en cycles=%0d finished=%0d expected %0d cycles and finished=1", obs, since >= 3, NW);
    end
  endtask

  task automatic test_start_priority();
    bit          seen_done = 0;
    int          obs = 0;
    logic [15:0] d = 16'($urandom);
    logic [29:0] exp_en = 30'(1) << 7;
    start = 1'b1; cfg_valid = 1'b1; cfg_layer = 8'd1; cfg_neuron = 8'd7; cfg_data = d; cfg_last = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_ready: cfg_ready=%b expected 0", cfg_ready);
    end
    @(posedge clk); @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_busy: busy=%b cfg_ready=%b expected 1 0", busy, cfg_ready);
    end
    for (int c = 0; c < 1000 && !seen_done; c++) begin
      #1;
      obs += int'(rd_en);
      seen_done = done;
      if (cfg_ready !== 1'b0 || wr_en !== '0) begin
        checks++; errors++;
        $display("FAIL prio_hold: cfg_ready=%b wr_en=%h expected 0 0", cfg_ready, wr_en);
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (!seen_done || obs != NW || cfg_ready !== 1'b1 || wr_en !== '0) begin
      errors++;
      $display("FAIL prio_after_done: done_seen=%b reads=%0d cfg_ready=%b wr_en=%h expected 1 %0d 1 0",
               seen_done, obs, cfg_ready, wr_en, NW);
    end
    @(posedge clk); @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if (wr_en !== exp_en || wr_addr !== 10'(m_cnt) || wr_data !== d) begin
      errors++;
      $display("FAIL prio_write: wr_en=%h wr_addr=%0d wr_data=%h expected %h %0d %h",
               wr_en, wr_addr, wr_data, exp_en, m_cnt, d);
    end
    m_cnt = (m_cnt == NW-1) ? 0 : m_cnt + 1;
    if (m_cnt == 0) m_err = 1;
  endtask

  task automatic test_reset_mid_read();
    start = 1'b1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0; m_err = 0;
    #1;
    checks++;
    if (busy !== 0 || rd_en !== 0 || rd_addr !== 0 || done !== 0 || err !== 0) begin
      errors++;
      $display("FAIL midreset: busy=%b rd_en=%b rd_addr=%0d done=%b err=%b expected all 0",
               busy, rd_en, rd_addr, done, err);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (done !== 0 || busy !== 0 || rd_en !== 0) begin
        errors++;
        $display("FAIL midreset_quiet: done=%b busy=%b rd_en=%b expected 0 0 0", done, busy, rd_en);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_neuron3();
    test_drop();
    test_err();
    test_random_load();
    run_read(-1, 0, 100, 1'b0);
    run_read(100, 5, 100, 1'b0);
    run_read(-1, 0, 70, 1'b1);
    test_start_priority();
    send_beat(8'd1, 8'd2, 16'($urandom), 1'b1);
    test_reset_mid_read();
    send_beat(8'd1, 8'd4, 16'($urandom), 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
